ps2_decoder: RTL

PS2_DECODER -- requirements
Module: ps2_decoder

---
 rtl/ps2_decoder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ps2_decoder.sv
`default_nettype none
// ============================================================================
// ps2_decoder : PS/2 keyboard receiver, set-2 scan codes with E0/F0 handling
// Revision    : 1.0
// ============================================================================
module ps2_decoder #(
  parameter int          FILTER  = 8,
  parameter logic [15:0] TIMEOUT = 16'd3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2ck,
  input  logic       ps2d,
  output logic       strb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext,
  output logic       perr
);

  localparam logic [3:0] c_filt_max = 4'(FILTER - 1);
  localparam logic [3:0] c_last_bit = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  logic        r_ck_s1, r_ck_s2, r_d_s1, r_d_s2;
  logic        r_ck_filt;
  logic [3:0]  r_filt_cnt;
  logic [15:0] r_idle;
  state_t      r_state;
  logic [3:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic        r_par;
  logic        r_stop;
  logic        r_brk;
  logic        r_ext;

  logic w_fall;
  logic w_timeout;
  logic w_frame_ok;

  // The filtered clock flips on the FILTER-th consecutive differing sample.
  assign w_fall     = r_ck_filt && !r_ck_s2 && (r_filt_cnt == c_filt_max);
  assign w_timeout  = (r_bitcnt != 4'd0) && (r_idle == TIMEOUT);
  assign w_frame_ok = r_stop && (^{r_shift, r_par});

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ck_s1    <= 1'b1;
      r_ck_s2    <= 1'b1;
      r_d_s1     <= 1'b1;
      r_d_s2     <= 1'b1;
      r_ck_filt  <= 1'b1;
      r_filt_cnt <= 4'd0;
      r_idle     <= 16'd0;
    end else begin
      r_ck_s1 <= ps2ck;
      r_ck_s2 <= r_ck_s1;
      r_d_s1  <= ps2d;
      r_d_s2  <= r_d_s1;

      if (r_ck_s2 == r_ck_filt) begin
        r_filt_cnt <= 4'd0;
      end else if (r_filt_cnt == c_filt_max) begin
        r_ck_filt  <= r_ck_s2;
        r_filt_cnt <= 4'd0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 4'd1;
      end

      if (w_fall) begin
        r_idle <= 16'd0;
      end else if (r_idle != TIMEOUT) begin
        r_idle <= r_idle + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_bitcnt <= 4'd0;
      r_shift  <= 8'h00;
      r_par    <= 1'b0;
      r_stop   <= 1'b0;
      r_brk    <= 1'b0;
      r_ext    <= 1'b0;
      strb     <= 1'b0;
      perr     <= 1'b0;
      make     <= 1'b1;
      code     <= 8'h00;
      ext      <= 1'b0;
    end else begin
      strb <= 1'b0;
      perr <= 1'b0;
      case (r_state)
        IDLE: begin
          // A high start bit is treated as noise and silently dropped.
          if (w_fall && !r_d_s2) begin
            r_state  <= RECV;
            r_bitcnt <= 4'd1;
          end
        end
        RECV: begin
          if (w_fall) begin
            if (r_bitcnt <= 4'd8) begin
              r_shift <= {r_d_s2, r_shift[7:1]};
            end else if (r_bitcnt == 4'd9) begin
              r_par <= r_d_s2;
            end else begin
              r_stop <= r_d_s2;
            end
            if (r_bitcnt == c_last_bit) begin
              r_bitcnt <= 4'd0;
              r_state  <= CHECK;
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end else if (w_timeout) begin
            r_bitcnt <= 4'd0;
            r_state  <= IDLE;
          end
        end
        CHECK: begin
          r_state <= IDLE;
          if (!w_frame_ok) begin
            perr  <= 1'b1;
            r_brk <= 1'b0;
            r_ext <= 1'b0;
          end else if (r_shift == 8'hF0) begin
            r_brk <= 1'b1;
          end else if (r_shift == 8'hE0) begin
            r_ext <= 1'b1;
          end else begin
            strb  <= 1'b1;
            code  <= r_shift;
            make  <= r_brk;
            ext   <= r_ext;
            r_brk <= 1'b0;
            r_ext <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_bitcnt <= 4'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
